// File: rtl/bcd_display_scan.sv
// Three-digit multiplexed 7-segment scanner for a BCD converter.
// Digits are captured into shadow registers whenever rdy is high and shown
// one at a time (units, tens, hundreds). Each slot is 2^REFRESH_BITS clocks
// long; the first cycle of every slot is a blank guard cycle so the anode
// change never ghosts the previous pattern. seg and an are active-low.
module bcd_display_scan #(
    parameter int REFRESH_BITS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] fdig,
    input  logic [3:0] sdig,
    input  logic [3:0] tdig,
    input  logic       rdy,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       frame_tick
);

    localparam logic [REFRESH_BITS-1:0] PRESC_MAX = '1;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [2:0] AN_OFF   = 3'b111;

    logic [REFRESH_BITS-1:0] presc_r;
    logic [1:0]              idx_r;
    logic [3:0]              units_r;
    logic [3:0]              tens_r;
    logic [3:0]              hund_r;
    logic                    valid_r;
    logic [6:0]              seg_r;
    logic [2:0]              an_r;
    logic                    frame_tick_r;

    logic                    slot_tick_s;
    logic [1:0]              idx_next_s;
    logic [3:0]              cur_dig_s;
    logic                    blank_s;
    logic [2:0]              an_next_s;

    // BCD to active-low {g,f,e,d,c,b,a}; anything above 9 renders as a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = SEG_DASH;
        endcase
    endfunction

    assign slot_tick_s = (presc_r == PRESC_MAX);
    assign seg         = seg_r;
    assign an          = an_r;
    assign frame_tick  = frame_tick_r;

    // Select the current digit, its anode, the next index and the blanking decision.
    always_comb begin
        cur_dig_s  = units_r;
        an_next_s  = AN_OFF;
        idx_next_s = 2'd0;
        blank_s    = 1'b0;

        case (idx_r)
            2'd0: begin
                cur_dig_s = units_r;
                an_next_s = 3'b110;
            end
            2'd1: begin
                cur_dig_s = tens_r;
                an_next_s = 3'b101;
            end
            2'd2: begin
                cur_dig_s = hund_r;
                an_next_s = 3'b011;
            end
            default: begin
                cur_dig_s = units_r;
                an_next_s = AN_OFF;
            end
        endcase

        if (idx_r == 2'd2) begin
            idx_next_s = 2'd0;
        end else begin
            idx_next_s = idx_r + 2'd1;
        end

        // Nothing is shown before the first capture; dashes always stay visible.
        if (!valid_r) begin
            blank_s = 1'b1;
        end else if (cur_dig_s > 4'd9) begin
            blank_s = 1'b0;
        end else if (blank_lz && (idx_r == 2'd2) && (hund_r == 4'd0)) begin
            blank_s = 1'b1;
        end else if (blank_lz && (idx_r == 2'd1) && (hund_r == 4'd0) && (tens_r == 4'd0)) begin
            blank_s = 1'b1;
        end else begin
            blank_s = 1'b0;
        end
    end

    // Prescaler and digit index: the prescaler wrap advances the index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_r <= '0;
            idx_r   <= 2'd0;
        end else begin
            presc_r <= presc_r + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
            if (slot_tick_s) begin
                idx_r <= idx_next_s;
            end else begin
                idx_r <= idx_r;
            end
        end
    end

    // Shadow digit capture with a sticky valid flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            units_r <= 4'd0;
            tens_r  <= 4'd0;
            hund_r  <= 4'd0;
            valid_r <= 1'b0;
        end else if (rdy) begin
            units_r <= fdig;
            tens_r  <= sdig;
            hund_r  <= tdig;
            valid_r <= 1'b1;
        end else begin
            units_r <= units_r;
            tens_r  <= tens_r;
            hund_r  <= hund_r;
            valid_r <= valid_r;
        end
    end

    // Registered display drive: guard cycle on the slot tick, else the current digit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_r         <= AN_OFF;
            seg_r        <= SEG_OFF;
            frame_tick_r <= 1'b0;
        end else begin
            frame_tick_r <= slot_tick_s && (idx_r == 2'd2);
            if (slot_tick_s) begin
                an_r  <= AN_OFF;
                seg_r <= SEG_OFF;
            end else begin
                an_r  <= an_next_s;
                seg_r <= blank_s ? SEG_OFF : seg_decode(cur_dig_s);
            end
        end
    end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan with REFRESH_BITS=2 (4-clock slots).
// A cycle model, indexed by the number of edges since reset release, pushes
// the expected an/seg/frame_tick for each edge; the values are popped and
// compared one time unit after that edge.
module tb_bcd_display_scan;

    localparam int N = 4;

    logic       clk;
    logic       rst;
    logic [3:0] fdig;
    logic [3:0] sdig;
    logic [3:0] tdig;
    logic       rdy;
    logic       blank_lz;
    logic [6:0] seg;
    logic [2:0] an;
    logic       frame_tick;

    typedef struct {
        logic [2:0] an;
        logic [6:0] seg;
        logic       ft;
    } exp_t;

    exp_t q[$];

    int n_cmp;
    int n_bad;

    int         m_k;
    logic [3:0] m_u;
    logic [3:0] m_t;
    logic [3:0] m_h;
    logic       m_valid;

    logic [6:0] pat [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    bcd_display_scan #(.REFRESH_BITS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .fdig       (fdig),
        .sdig       (sdig),
        .tdig       (tdig),
        .rdy        (rdy),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] model_seg(input int idx);
        logic [3:0] d;
        if (idx == 0)      d = m_u;
        else if (idx == 1) d = m_t;
        else               d = m_h;
        if (!m_valid)                                               return 7'b1111111;
        if (d > 4'd9)                                               return 7'b0111111;
        if (blank_lz && idx == 2 && m_h == 4'd0)                    return 7'b1111111;
        if (blank_lz && idx == 1 && m_h == 4'd0 && m_t == 4'd0)     return 7'b1111111;
        return pat[d];
    endfunction

    task automatic model_reset();
        m_k     = 0;
        m_u     = 4'd0;
        m_t     = 4'd0;
        m_h     = 4'd0;
        m_valid = 1'b0;
    endtask

    // One clock: predict, push, update model, take the edge, pop and compare.
    task automatic step();
        exp_t e;
        int   k;
        int   idx;
        k = m_k + 1;
        if (k % N == 0) begin
            e.an  = 3'b111;
            e.seg = 7'b1111111;
        end else begin
            idx   = (k / N) % 3;
            e.an  = ~(3'b001 << idx);
            e.seg = model_seg(idx);
        end
        e.ft = (k % (3 * N) == 0);
        q.push_back(e);
        if (rdy) begin
            m_u     = fdig;
            m_t     = sdig;
            m_h     = tdig;
            m_valid = 1'b1;
        end
        m_k = k;
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk("queue_empty", 32'd1, 32'd0);
        end else begin
            e = q.pop_front();
            chk("an", {29'd0, an}, {29'd0, e.an});
            chk("seg", {25'd0, seg}, {25'd0, e.seg});
            chk("frame_tick", {31'd0, frame_tick}, {31'd0, e.ft});
        end
    endtask

    task automatic load(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u,
                        input logic bl, input int cycles);
        tdig     = h;
        sdig     = t;
        fdig     = u;
        blank_lz = bl;
        rdy      = 1'b1;
        step();
        rdy = 1'b0;
        for (int i = 0; i < cycles; i++) step();
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst      = 1'b1;
        rdy      = 1'b0;
        fdig     = 4'd0;
        sdig     = 4'd0;
        tdig     = 4'd0;
        blank_lz = 1'b0;
        model_reset();

        // Reset state, held across clock edges.
        #3 rst = 1'b0;
        #1;
        chk("rst_an", {29'd0, an}, 32'd7);
        chk("rst_seg", {25'd0, seg}, 32'h7f);
        #18;
        chk("rst_an_held", {29'd0, an}, 32'd7);
        chk("rst_seg_held", {25'd0, seg}, 32'h7f);
        chk("rst_ft_held", {31'd0, frame_tick}, 32'd0);

        // Release between edges; scan with no data yet.
        @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
        for (int i = 0; i < 30; i++) step();

        // Directed display patterns.
        load(4'd2, 4'd5, 4'd5, 1'b0, 14);
        load(4'd0, 4'd0, 4'd7, 1'b1, 14);
        load(4'd0, 4'd0, 4'd7, 1'b0, 14);
        load(4'd0, 4'hC, 4'd3, 1'b1, 14);
        load(4'hA, 4'd0, 4'd0, 1'b1, 14);

        // Mid-slot update of the units digit 5 -> 8.
        for (int i = 0; i < 3 * N && (m_k % (3 * N)) != 0; i++) step();
        load(4'd0, 4'd0, 4'd5, 1'b0, 0);
        load(4'd0, 4'd0, 4'd8, 1'b0, 6);

        // Capture coincident with the slot tick.
        for (int i = 0; i < N && ((m_k + 1) % N) != 0; i++) step();
        load(4'd9, 4'd1, 4'd4, 1'b0, 13);

        // Random traffic.
        for (int i = 0; i < 150; i++) begin
            rdy      = ($urandom_range(0, 3) == 0);
            fdig     = 4'($urandom_range(0, 15));
            sdig     = 4'($urandom_range(0, 15));
            tdig     = 4'($urandom_range(0, 15));
            blank_lz = 1'($urandom_range(0, 1));
            step();
        end
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) step();

        // Asynchronous reset in the middle of a slot, between edges.
        #2 rst = 1'b0;
        #1;
        chk("midrst_an", {29'd0, an}, 32'd7);
        chk("midrst_seg", {25'd0, seg}, 32'h7f);
        chk("midrst_ft", {31'd0, frame_tick}, 32'd0);
        @(posedge clk);
        #1;
        chk("midrst_an_held", {29'd0, an}, 32'd7);
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 14; i++) step();
        load(4'd1, 4'd2, 4'd3, 1'b0, 14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
